// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue FSM in front of the ALU core; owns the accumulator and carry/zero flags.
// Optional build macro ALU_TIMEOUT_EN: bounds the WAIT state and raises a sticky err on expiry.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_operand,
    output logic       alu_start,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_z,
    output logic       busy,
    output logic       err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LOAD = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] operand;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITEBACK} state_t;

    cmd_t          fifo [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    state_t        state, state_nxt;
    logic [2:0]    cur_op;
    logic [7:0]    cur_operand;
    logic [7:0]    res;
    logic          res_c;
    logic          tmo_hit;

    assign head      = fifo[rd_ptr];
    assign cmd_ready = (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && ena && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{op: cmd_op, operand: cmd_operand};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_start = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_nxt = (head.op <= OP_XOR) ? ISSUE : WRITEBACK;
            end
            ISSUE: begin
                alu_start = 1'b1;
                state_nxt = alu_done ? WRITEBACK : WAIT;
            end
            WAIT: begin
                if (alu_done)     state_nxt = WRITEBACK;
                else if (tmo_hit) state_nxt = IDLE;
            end
            WRITEBACK: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            cur_op      <= '0;
            cur_operand <= '0;
            res         <= '0;
            res_c       <= 1'b0;
            acc         <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b1;
        end else begin
            if (pop) begin
                cur_op      <= head.op;
                cur_operand <= head.operand;
                if (head.op <= OP_XOR) begin
                    alu_op <= head.op;
                    alu_a  <= acc;
                    alu_b  <= head.operand;
                end
            end
            if ((state == ISSUE || state == WAIT) && alu_done) begin
                res   <= alu_result;
                res_c <= alu_carry;
            end
            if (state == WRITEBACK) begin
                case (cur_op)
                    OP_ADD, OP_SUB: begin
                        acc    <= res;
                        flag_c <= res_c;
                        flag_z <= (res == 8'h00);
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        acc    <= res;
                        flag_c <= 1'b0;
                        flag_z <= (res == 8'h00);
                    end
                    OP_LOAD: begin
                        acc    <= cur_operand;
                        flag_c <= 1'b0;
                        flag_z <= (cur_operand == 8'h00);
                    end
                    OP_CLR: begin
                        acc    <= '0;
                        flag_c <= 1'b0;
                        flag_z <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    // A done arriving in the final WAIT cycle still wins over the timeout.
    assign tmo_hit = (state == WAIT) && !alu_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            if (state == ISSUE)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 1'b1;
            if (state == WRITEBACK && cur_op == OP_CLR) err <= 1'b0;
            else if (tmo_hit)                           err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stub of programmable latency.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       alu_start;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [7:0] acc;
    logic       flag_c, flag_z, busy, err;

    int n_assert = 0;
    int n_fail   = 0;
    int starts   = 0;
    int alu_delay = 0;
    int wcnt     = 0;
    int s0;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_carry(alu_carry),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // ALU stub: combinational result, done either with start or alu_delay cycles later.
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_op)
            3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            default: ;
        endcase
    end

    assign alu_done = (alu_delay == 0) ? alu_start : (wcnt == alu_delay);

    always @(posedge clk) begin
        if (alu_start) starts <= starts + 1;
        if (alu_start)                          wcnt <= 1;
        else if (wcnt > 0 && wcnt < alu_delay)  wcnt <= wcnt + 1;
        else                                    wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] val);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = val;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        ena = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_operand = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // 1: reset state
        chk("rst_acc", acc, 8'h00);
        chk("rst_z", flag_z, 1);
        chk("rst_c", flag_c, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_err", err, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: LOAD 5, ADD 3 with cycle-accurate issue checks
        push(3'd5, 8'h05);
        wait_idle(10);
        chk("load5_acc", acc, 8'h05);
        push(3'd0, 8'h03);
        chk("add_q_start", alu_start, 0);
        chk("add_q_busy", busy, 1);
        @(negedge clk);
        chk("add_issue_start", alu_start, 1);
        chk("add_issue_a", alu_a, 8'h05);
        chk("add_issue_b", alu_b, 8'h03);
        chk("add_issue_op", alu_op, 3'd0);
        @(negedge clk);
        chk("add_wb_start", alu_start, 0);
        @(negedge clk);
        chk("add_acc", acc, 8'h08);
        chk("add_z", flag_z, 0);
        chk("add_c", flag_c, 0);

        // 3: wrap to zero with carry, then borrow
        push(3'd5, 8'hFF);
        push(3'd0, 8'h01);
        wait_idle(20);
        chk("wrap_acc", acc, 8'h00);
        chk("wrap_c", flag_c, 1);
        chk("wrap_z", flag_z, 1);
        push(3'd1, 8'h01);
        wait_idle(20);
        chk("sub_acc", acc, 8'hFF);
        chk("sub_c", flag_c, 1);
        chk("sub_z", flag_z, 0);

        // 4: fill with ena low, then drain; second batch wraps the pointers
        ena = 1'b0;
        s0 = starts;
        push(3'd5, 8'h10);
        push(3'd0, 8'h01);
        push(3'd4, 8'hFF);
        push(3'd2, 8'h0F);
        chk("full_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        push(3'd0, 8'h77);
        chk("full_ready2", cmd_ready, 0);
        chk("full_nostart", starts - s0, 0);
        ena = 1'b1;
        wait_idle(40);
        chk("drain_acc", acc, 8'h0E);
        chk("drain_c", flag_c, 0);
        chk("drain_starts", starts - s0, 3);
        push(3'd3, 8'h30);
        push(3'd1, 8'h3F);
        push(3'd7, 8'h99);
        push(3'd0, 8'h02);
        wait_idle(40);
        chk("wrap2_acc", acc, 8'h01);
        chk("wrap2_c", flag_c, 1);
        chk("wrap2_z", flag_z, 0);

        // 5: delayed done keeps ALU inputs stable; then async reset from WAIT
        alu_delay = 3;
        push(3'd5, 8'h20);
        wait_idle(10);
        push(3'd1, 8'h05);
        @(negedge clk);
        chk("dly_issue", alu_start, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dly_wait_start", alu_start, 0);
            chk("dly_wait_a", alu_a, 8'h20);
            chk("dly_wait_b", alu_b, 8'h05);
            chk("dly_wait_op", alu_op, 3'd1);
        end
        wait_idle(10);
        chk("dly_acc", acc, 8'h1B);
        chk("dly_c", flag_c, 0);
        push(3'd5, 8'h44);
        wait_idle(10);
        push(3'd0, 8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_acc", acc, 8'h00);
        chk("arst_z", flag_z, 1);
        chk("arst_a", alu_a, 8'h00);
        chk("arst_b", alu_b, 8'h00);
        chk("arst_op", alu_op, 3'd0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("late_done_ignored", acc, 8'h00);
        chk("late_done_busy", busy, 0);

`ifdef ALU_TIMEOUT_EN
        // 6: ALU never answers -> timeout after 15 WAIT cycles, CLR clears err
        push(3'd5, 8'h5A);
        wait_idle(10);
        alu_delay = 1000;
        push(3'd0, 8'h01);
        @(negedge clk);
        chk("tmo_issue", alu_start, 1);
        repeat (15) @(negedge clk);
        chk("tmo_err_pre", err, 0);
        chk("tmo_busy_pre", busy, 1);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_acc", acc, 8'h5A);
        push(3'd6, 8'h00);
        wait_idle(10);
        chk("clr_err", err, 0);
        chk("clr_acc", acc, 8'h00);
        chk("clr_z", flag_z, 1);
`else
        chk("no_tmo_err", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
